time_setter: RTL
================

Name: time_setter

Overview:
- Front-panel preset and start controller that sits directly upstream of the countdown timer.
- Debounces four raw push-buttons, maintains the minute/second preset registers, and issues a one-cycle START pulse.
- Tracks run/expiry by watching the timer's TIME_UP output.
- Outputs connect straight to the timer's TIME_MIN, TIME_SEC and START inputs.

Parameters:
- DEB_CYCLES, 4: number of consecutive synchronized samples required to accept a key level change (min 2).
- MAX_MIN, 7: largest minute preset value; wraps to 0 after it (must fit 3 bits).
- MAX_SEC, 59: largest second preset value; wraps to 0 after it (must fit 6 bits).

Ports:
- SYSCLK  in  1  system clock, rising edge.
- RST_B  in  1  asynchronous active-low reset.
- KEY_MIN  in  1  raw button, active-high, asynchronous: increment minutes.
- KEY_SEC  in  1  raw button, active-high, asynchronous: increment seconds.
- KEY_CLR  in  1  raw button, active-high, asynchronous: clear presets.
- KEY_START  in  1  raw button, active-high, asynchronous: start countdown.
- TIME_UP  in  1  from timer, synchronous to SYSCLK: countdown expired.
- TIME_MIN  out  3  minute preset to timer.
- TIME_SEC  out  6  second preset to timer.
- START  out  1  one-cycle start pulse to timer.
- BUSY  out  1  high while countdown is running.
- ALARM  out  1  high from expiry until acknowledged.

Behaviour:
- Reset (RST_B low, async): TIME_MIN=0, TIME_SEC=0, START=0, BUSY=0, ALARM=0, state=SET; all sync flops, debounced levels, counters and TIME_UP history are cleared to 0. Reset asserted mid-run aborts to SET with the presets cleared.
- Per key: 2-flop synchronizer, then debouncer.
  - The debounced level toggles on the edge where the synchronized value has differed from it for DEB_CYCLES consecutive samples; any matching sample resets the counter.
  - A press event is a registered one-cycle pulse on a debounced 0->1 transition. Release produces no event.
  - Holding a key gives exactly one event; there is no auto-repeat.
- Latency: raw key goes high before edge k and stays high -> the resulting register update or START occurs at edge k+DEB_CYCLES+2.
- Glitches shorter than DEB_CYCLES cycles (after synchronization) produce no event.
- States: SET, RUN, DONE (2-bit encoding).
- SET:
  - MIN event: TIME_MIN+1, wrapping MAX_MIN->0.
  - SEC event: TIME_SEC+1, wrapping MAX_SEC->0.
  - CLR event: both presets -> 0.
  - START event with a nonzero preset ({TIME_MIN,TIME_SEC}!=0): START=1 for exactly one cycle, same edge state->RUN, BUSY->1.
  - START event with a zero preset: ignored, no pulse, stays in SET.
- Same-cycle event priority: CLR > START > {MIN, SEC}.
  - MIN and SEC together both apply.
  - CLR and START together: clear only, no start.
  - START together with MIN/SEC: start with the unmodified presets; MIN/SEC are dropped.
- RUN:
  - Presets are frozen; all key events are ignored.
  - A TIME_UP rising edge (high now, low on the previous cycle) -> DONE, BUSY=0, ALARM=1.
  - TIME_UP history is reset to 1 on the START edge, so a stale high level from a previous run cannot trigger DONE. An actual rising edge is required.
- DONE:
  - ALARM holds 1.
  - Any key event (any of the four) -> SET, ALARM=0. That event is consumed, not applied.
  - Presets are retained so the same time can be restarted.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset/idle: RST_B low at t=0, release at 20ns -> all outputs 0, state SET; START key with zero preset -> no START pulse, BUSY stays 0.
- Preset entry, DEB_CYCLES=4, 10ns clock: press KEY_MIN 3 times and KEY_SEC 48 times, each press 100ns high / 100ns low -> TIME_MIN=3, TIME_SEC=48. Each update lands exactly 6 edges after the raw rise.
- Wrap and clear: 8 MIN presses -> TIME_MIN returns to 0; 60 SEC presses -> TIME_SEC returns to 0; then CLR -> both 0.
- Bounce rejection: KEY_SEC toggled every 20ns for 200ns, then held high -> exactly one increment. A 2-cycle glitch produces no increment.
- Start/run/done: preset 0:05, press START -> START high for one cycle, BUSY=1. MIN press during RUN -> TIME_MIN unchanged. TIME_UP held high 40 cycles later -> BUSY=0, ALARM=1. Any key -> ALARM=0, state SET, presets still 0:05.
- Priority and reset: CLR and START pressed together -> presets 0, no START. RST_B pulsed low mid-RUN -> immediate async return to all-zero outputs, state SET.

Source files
------------

// File: rtl/time_setter.sv
`timescale 1ns/1ps
// time_setter: debounces the four front-panel keys, holds the minute/second
// preset and drives START/BUSY/ALARM around the downstream countdown timer.
module time_setter #(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_MIN    = 7,
  parameter int MAX_SEC    = 59
) (
  input  logic       SYSCLK,
  input  logic       RST_B,
  input  logic       KEY_MIN,
  input  logic       KEY_SEC,
  input  logic       KEY_CLR,
  input  logic       KEY_START,
  input  logic       TIME_UP,
  output logic [2:0] TIME_MIN,
  output logic [5:0] TIME_SEC,
  output logic       START,
  output logic       BUSY,
  output logic       ALARM
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    MIN_LAST = 3'(MAX_MIN);
  localparam logic [5:0]    SEC_LAST = 6'(MAX_SEC);

  localparam logic [1:0] ST_SET  = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Key index: 0 = MIN, 1 = SEC, 2 = CLR, 3 = START.
  logic [3:0]    raw_s;
  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [3:0]    level_r;
  logic [3:0]    evt_r;
  logic [CW-1:0] cnt_r [4];

  logic [1:0] state_r, state_s;
  logic [2:0] min_r, min_s;
  logic [5:0] sec_r, sec_s;
  logic       start_r, start_s;
  logic       busy_r, busy_s;
  logic       alarm_r, alarm_s;
  logic       tu_prev_r, tu_prev_s;
  logic       preset_nz_s;
  logic       tu_rise_s;

  assign raw_s       = {KEY_START, KEY_CLR, KEY_SEC, KEY_MIN};
  assign preset_nz_s = (min_r != 3'd0) || (sec_r != 6'd0);
  assign tu_rise_s   = TIME_UP && !tu_prev_r;

  // Synchronize each key, then accept a level change only after DEB_CYCLES differing samples.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      level_r <= 4'b0000;
      evt_r   <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] != level_r[i]) begin
          if (cnt_r[i] == CNT_LAST) begin
            level_r[i] <= sync2_r[i];
            cnt_r[i]   <= {CW{1'b0}};
            evt_r[i]   <= sync2_r[i];
          end else begin
            cnt_r[i] <= cnt_r[i] + CNT_ONE;
            evt_r[i] <= 1'b0;
          end
        end else begin
          cnt_r[i] <= {CW{1'b0}};
          evt_r[i] <= 1'b0;
        end
      end
    end
  end

  // Preset editing and run/expiry control; CLR beats START beats MIN/SEC.
  always_comb begin
    state_s   = state_r;
    min_s     = min_r;
    sec_s     = sec_r;
    start_s   = 1'b0;
    busy_s    = busy_r;
    alarm_s   = alarm_r;
    tu_prev_s = TIME_UP;
    case (state_r)
      ST_SET: begin
        if (evt_r[2]) begin
          min_s = 3'd0;
          sec_s = 6'd0;
        end else if (evt_r[3]) begin
          if (preset_nz_s) begin
            start_s   = 1'b1;
            busy_s    = 1'b1;
            state_s   = ST_RUN;
            tu_prev_s = 1'b1;
          end else begin
            start_s = 1'b0;
          end
        end else begin
          if (evt_r[0]) begin
            min_s = (min_r == MIN_LAST) ? 3'd0 : min_r + 3'd1;
          end else begin
            min_s = min_r;
          end
          if (evt_r[1]) begin
            sec_s = (sec_r == SEC_LAST) ? 6'd0 : sec_r + 6'd1;
          end else begin
            sec_s = sec_r;
          end
        end
      end
      ST_RUN: begin
        if (tu_rise_s) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          alarm_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        // The acknowledging key press is swallowed, presets stay for a restart.
        if (evt_r != 4'b0000) begin
          state_s = ST_SET;
          alarm_s = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_SET;
        busy_s  = 1'b0;
        alarm_s = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge SYSCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_r   <= ST_SET;
      min_r     <= 3'd0;
      sec_r     <= 6'd0;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      alarm_r   <= 1'b0;
      tu_prev_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      min_r     <= min_s;
      sec_r     <= sec_s;
      start_r   <= start_s;
      busy_r    <= busy_s;
      alarm_r   <= alarm_s;
      tu_prev_r <= tu_prev_s;
    end
  end

  assign TIME_MIN = min_r;
  assign TIME_SEC = sec_r;
  assign START    = start_r;
  assign BUSY     = busy_r;
  assign ALARM    = alarm_r;

endmodule
